// File: rtl/ot_uart_pkg.sv
// ot_uart_pkg: shared constants, FSM encodings and a clog2 helper for the
// buffered UART (ot_uart_buffered) and its FIFO (ot_uart_sync_fifo).
package ot_uart_pkg;
   localparam int OVERSAMPLE = 16;  // ticks per serial bit
   localparam int MID_SAMPLE = 8;   // tick within a bit where RX samples

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/ot_uart_buffered_if.sv
// ot_uart_buffered_if: byte-parallel side of the UART (bus bridge <-> UART).
//  master : bridge side (drives data_in/wr_en/rd_en/clear)
//  slave  : UART side (drives tx_full, data_out, rx_empty and the RX flags)
interface ot_uart_buffered_if #(parameter int DATA_BITS = 8);
   logic [DATA_BITS-1:0] data_in;
   logic                 wr_en;
   logic                 tx_full;
   logic [DATA_BITS-1:0] data_out;
   logic                 rd_en;
   logic                 rx_empty;
   logic                 rx_overrun;
   logic                 frame_err;
   logic                 parity_err;
   logic                 clear;

   modport master (output data_in, wr_en, rd_en, clear,
                   input  tx_full, data_out, rx_empty, rx_overrun, frame_err, parity_err);
   modport slave  (input  data_in, wr_en, rd_en, clear,
                   output tx_full, data_out, rx_empty, rx_overrun, frame_err, parity_err);
endinterface

// File: rtl/ot_uart_sync_fifo.sv
// ot_uart_sync_fifo: first-word fall-through synchronous FIFO.
//  clk/rstn   clock, async active-low reset
//  push/pop   already qualified by the caller (no internal full/empty guard)
//  din/dout   write data / head of queue (0 while empty)
//  full/empty status from extended-pointer MSB compare
module ot_uart_sync_fifo import ot_uart_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = clog2(DEPTH);

   logic [AW:0]      wptr, rptr;
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   // A push while full is only legal with a same-cycle pop; the write then
   // lands in the slot the pop is vacating.
   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= din;
   end

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign dout  = empty ? '0 : mem[rptr[AW-1:0]];
endmodule

// File: rtl/ot_uart_buffered.sv
// ot_uart_buffered: 16x-oversampled UART with TX/RX FIFOs.
//  clk_50m   system clock          rstn     async active-low reset
//  baud_div  tick period-1         bus      byte side (ot_uart_buffered_if.slave)
//  Tx        serial out, idle high Tx_busy  TX FSM active or TX FIFO non-empty
//  Rx        async serial in
// Optional feature: define OT_UART_PARITY_EN for an even parity bit on TX and
// parity checking on RX; otherwise parity_err is tied 0.
module ot_uart_buffered import ot_uart_pkg::*; #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_W      = 16
) (
   input  logic             clk_50m,
   input  logic             rstn,
   input  logic [DIV_W-1:0] baud_div,
   ot_uart_buffered_if.slave bus,
   output logic             Tx,
   output logic             Tx_busy,
   input  logic             Rx
);
   localparam int IDX_W = clog2(DATA_BITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   // ---------------- baud tick (shared by TX and RX) ----------------
   logic [DIV_W-1:0] baud_cnt, div_q;
   logic             tick;

   assign tick = (baud_cnt == div_q);

   always_ff @(posedge clk_50m or negedge rstn) begin
      if (!rstn) begin
         baud_cnt <= '0;
         div_q    <= '0;
      end else if (tick) begin
         baud_cnt <= '0;
         div_q    <= baud_div;   // new divisor only takes effect at wrap
      end else begin
         baud_cnt <= baud_cnt + 1'b1;
      end
   end

   // ---------------- TX ----------------
   tx_state_t            tx_state, tx_state_n;
   logic [3:0]           tx_cnt, tx_cnt_n;
   logic [IDX_W-1:0]     tx_idx, tx_idx_n;
   logic [DATA_BITS-1:0] tx_data, tx_data_n, tx_head;
   logic                 tx_pop, tx_push, tx_full, tx_empty, tx_bend;

   assign tx_push     = bus.wr_en && !tx_full;  // dropped when full, pop or not
   assign tx_bend     = tick && (tx_cnt == 4'(OVERSAMPLE - 1));
   assign bus.tx_full = tx_full;
   assign Tx_busy     = (tx_state != TX_IDLE) || !tx_empty;

   ot_uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk_50m), .rstn(rstn), .push(tx_push), .pop(tx_pop),
      .din(bus.data_in), .dout(tx_head), .full(tx_full), .empty(tx_empty));

   always_ff @(posedge clk_50m or negedge rstn) begin
      if (!rstn) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_data  <= '0;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_idx   <= tx_idx_n;
         tx_data  <= tx_data_n;
      end
   end

   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_idx_n   = tx_idx;
      tx_data_n  = tx_data;
      tx_pop     = 1'b0;
      if (tx_state != TX_IDLE && tick) tx_cnt_n = tx_cnt + 4'd1;  // wraps 15->0 per bit
      case (tx_state)
         TX_IDLE: if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_data_n  = tx_head;
            tx_cnt_n   = '0;
            tx_state_n = TX_START;
         end
         TX_START: if (tx_bend) begin
            tx_idx_n   = '0;
            tx_state_n = TX_DATA;
         end
         TX_DATA: if (tx_bend) begin
            if (tx_idx == LAST_IDX) begin
`ifdef OT_UART_PARITY_EN
               tx_state_n = TX_PARITY;
`else
               tx_state_n = TX_STOP;
`endif
            end else begin
               tx_idx_n = tx_idx + 1'b1;
            end
         end
         TX_PARITY: if (tx_bend) tx_state_n = TX_STOP;
         TX_STOP: if (tx_bend) begin
            // Back-to-back frames: next start bit follows the stop bit directly.
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_data_n  = tx_head;
               tx_state_n = TX_START;
            end else begin
               tx_state_n = TX_IDLE;
            end
         end
         default: tx_state_n = TX_IDLE;
      endcase
   end

   // Decoded straight from registers so reset forces the line high at once.
   always_comb begin
      case (tx_state)
         TX_START:  Tx = 1'b0;
         TX_DATA:   Tx = tx_data[tx_idx];
         TX_PARITY: Tx = ^tx_data;
         default:   Tx = 1'b1;
      endcase
   end

   // ---------------- RX ----------------
   rx_state_t            rx_state, rx_state_n;
   logic [3:0]           rx_cnt, rx_cnt_n;
   logic [IDX_W-1:0]     rx_idx, rx_idx_n;
   logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
   logic [1:0]           rx_sync;
   logic                 rx_prev, rx_s, rx_mid, rx_bend;
   logic                 rx_push_req, rx_push, rx_pop, rx_full, rx_empty, rx_ovf;
   logic                 fe_set, frame_err_q, overrun_q;
`ifdef OT_UART_PARITY_EN
   logic                 rx_pbit, rx_pbit_n, pe_set, parity_err_q;
`endif

   assign rx_s    = rx_sync[1];
   assign rx_mid  = tick && (rx_cnt == 4'(MID_SAMPLE - 1));
   assign rx_bend = tick && (rx_cnt == 4'(OVERSAMPLE - 1));

   assign rx_pop  = bus.rd_en && !rx_empty;
   assign rx_push = rx_push_req && (!rx_full || rx_pop);
   assign rx_ovf  = rx_push_req && rx_full && !rx_pop;

   ot_uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk_50m), .rstn(rstn), .push(rx_push), .pop(rx_pop),
      .din(rx_sh), .dout(bus.data_out), .full(rx_full), .empty(rx_empty));

   assign bus.rx_empty   = rx_empty;
   assign bus.rx_overrun = overrun_q;
   assign bus.frame_err  = frame_err_q;
`ifdef OT_UART_PARITY_EN
   assign bus.parity_err = parity_err_q;
`else
   assign bus.parity_err = 1'b0;
`endif

   always_ff @(posedge clk_50m or negedge rstn) begin
      if (!rstn) begin
         rx_sync     <= 2'b11;
         rx_prev     <= 1'b1;
         rx_state    <= RX_IDLE;
         rx_cnt      <= '0;
         rx_idx      <= '0;
         rx_sh       <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         rx_sync     <= {rx_sync[0], Rx};
         rx_prev     <= rx_s;
         rx_state    <= rx_state_n;
         rx_cnt      <= rx_cnt_n;
         rx_idx      <= rx_idx_n;
         rx_sh       <= rx_sh_n;
         frame_err_q <= fe_set;
         // A new overrun wins over a same-cycle clear.
         if (rx_ovf)         overrun_q <= 1'b1;
         else if (bus.clear) overrun_q <= 1'b0;
      end
   end

`ifdef OT_UART_PARITY_EN
   always_ff @(posedge clk_50m or negedge rstn) begin
      if (!rstn) begin
         rx_pbit      <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         rx_pbit      <= rx_pbit_n;
         parity_err_q <= pe_set;
      end
   end
`endif

   always_comb begin
      rx_state_n  = rx_state;
      rx_cnt_n    = rx_cnt;
      rx_idx_n    = rx_idx;
      rx_sh_n     = rx_sh;
      rx_push_req = 1'b0;
      fe_set      = 1'b0;
`ifdef OT_UART_PARITY_EN
      rx_pbit_n   = rx_pbit;
      pe_set      = 1'b0;
`endif
      if (rx_state != RX_IDLE && tick) rx_cnt_n = rx_cnt + 4'd1;
      case (rx_state)
         RX_IDLE: if (rx_prev && !rx_s) begin
            rx_cnt_n   = '0;
            rx_state_n = RX_START;
         end
         RX_START: begin
            if (rx_mid && rx_s) rx_state_n = RX_IDLE;  // glitch: line back high mid-start
            else if (rx_bend) begin
               rx_idx_n   = '0;
               rx_state_n = RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_mid) rx_sh_n = {rx_s, rx_sh[DATA_BITS-1:1]};  // LSB arrives first
            if (rx_bend) begin
               if (rx_idx == LAST_IDX) begin
`ifdef OT_UART_PARITY_EN
                  rx_state_n = RX_PARITY;
`else
                  rx_state_n = RX_STOP;
`endif
               end else begin
                  rx_idx_n = rx_idx + 1'b1;
               end
            end
         end
         RX_PARITY: begin
`ifdef OT_UART_PARITY_EN
            if (rx_mid) rx_pbit_n = rx_s;
`endif
            if (rx_bend) rx_state_n = RX_STOP;
         end
         RX_STOP: if (rx_mid) begin
            // Leave at mid-stop so a start edge right after the stop bit is seen.
            rx_state_n = RX_IDLE;
            if (!rx_s) fe_set = 1'b1;
`ifdef OT_UART_PARITY_EN
            else if (rx_pbit != ^rx_sh) pe_set = 1'b1;
`endif
            else rx_push_req = 1'b1;
         end
         default: rx_state_n = RX_IDLE;
      endcase
   end
endmodule

// File: tb/tb_ot_uart_buffered.sv
// tb_ot_uart_buffered: directed, self-checking bench for ot_uart_buffered.
// RX frames are driven from a vector table; TX, FIFO-full, overrun, glitch,
// parity (OT_UART_PARITY_EN) and mid-frame reset are hand-written sequences.
module tb_ot_uart_buffered;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] baud_div = '0;
   logic        tx, tx_busy;
   logic        rx_drv = 1'b1;
   logic        loop = 1'b0;
   logic        rx_pin;

   int n_vec = 0;
   int n_err = 0;
   int ferr_cnt = 0;
   int perr_cnt = 0;

   assign rx_pin = loop ? tx : rx_drv;

   ot_uart_buffered_if #(.DATA_BITS(8)) bus ();

   ot_uart_buffered #(.DATA_BITS(8), .FIFO_DEPTH(8), .DIV_W(16)) dut (
      .clk_50m(clk), .rstn(rstn), .baud_div(baud_div), .bus(bus),
      .Tx(tx), .Tx_busy(tx_busy), .Rx(rx_pin));

   always #10 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   typedef struct {
      logic [7:0] d;
      logic       stop;
      logic       exp_store;
      logic       exp_ferr;
   } rxv_t;

   rxv_t tbl [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One serial bit on rx_drv; counts flag pulses while it is held.
   task automatic bit_hold(input logic b);
      rx_drv = b;
      repeat (16 * (int'(baud_div) + 1)) begin
         @(negedge clk);
         if (bus.frame_err)  ferr_cnt++;
         if (bus.parity_err) perr_cnt++;
      end
   endtask

   task automatic send_rx(input logic [7:0] d, input logic stop, input logic par);
      bit_hold(1'b0);
      for (int i = 0; i < 8; i++) bit_hold(d[i]);
`ifdef OT_UART_PARITY_EN
      bit_hold(par);
`endif
      bit_hold(stop);
      rx_drv = 1'b1;
   endtask

   task automatic pop1();
      bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
   endtask

   initial begin
      logic [7:0] b;
      logic       s [176];
      logic [7:0] got [$];
      int         t, zeros;

      tbl[0] = '{8'h55, 1'b1, 1'b1, 1'b0};
      tbl[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
      tbl[3] = '{8'h80, 1'b1, 1'b1, 1'b0};
      tbl[4] = '{8'h3C, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{8'h01, 1'b1, 1'b1, 1'b0};

      bus.data_in = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clear = 1'b0;

      // ---- reset state ----
      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_rx_empty", bus.rx_empty, 1);
      chk("rst_tx_full", bus.tx_full, 0);
      chk("rst_tx_busy", tx_busy, 0);
      chk("rst_data_out", bus.data_out, 0);
      chk("rst_overrun", bus.rx_overrun, 0);
      chk("rst_frame_err", bus.frame_err, 0);
      rstn = 1'b1;
      repeat (4) @(negedge clk);

      // ---- loopback 0xA5 at baud_div=0 ----
      loop = 1'b1;
      b = 8'hA5;
      bus.data_in = b; bus.wr_en = 1'b1;
      @(negedge clk);
      bus.wr_en = 1'b0;
      chk("a5_busy", tx_busy, 1);
      t = 0;
      while (tx !== 1'b0 && t < 50) begin @(negedge clk); t++; end
      chk("a5_start_seen", tx, 0);
      for (int i = 0; i < 176; i++) begin s[i] = tx; @(negedge clk); end
      zeros = 0;
      for (int i = 0; i < 16; i++) if (s[i] == 1'b0) zeros++;
      chk("a5_start_len", zeros, 16);
      chk("a5_start_end", s[16], 1);
      for (int i = 0; i < 8; i++) chk($sformatf("a5_bit%0d", i), s[24 + 16*i], b[i]);
`ifdef OT_UART_PARITY_EN
      chk("a5_parity", s[152], 0);
      chk("a5_stop", s[168], 1);
`else
      chk("a5_stop", s[152], 1);
`endif
      chk("a5_rx_empty", bus.rx_empty, 0);
      chk("a5_rx_data", bus.data_out, 8'hA5);
      repeat (20) @(negedge clk);
      chk("a5_idle_busy", tx_busy, 0);
      pop1();
      loop = 1'b0;

      // ---- RX vector table ----
      for (int v = 0; v < 6; v++) begin
         ferr_cnt = 0;
         send_rx(tbl[v].d, tbl[v].stop, ^tbl[v].d);
         bit_hold(1'b1);
         chk($sformatf("rxv%0d_ferr", v), ferr_cnt, {31'd0, tbl[v].exp_ferr});
         chk($sformatf("rxv%0d_empty", v), bus.rx_empty, !tbl[v].exp_store);
         if (tbl[v].exp_store) begin
            chk($sformatf("rxv%0d_data", v), bus.data_out, tbl[v].d);
            pop1();
            chk($sformatf("rxv%0d_popped", v), bus.rx_empty, 1);
         end
      end

      // ---- short low glitch: 4 ticks ----
      ferr_cnt = 0;
      rx_drv = 1'b0;
      repeat (4) @(negedge clk);
      rx_drv = 1'b1;
      repeat (200) begin @(negedge clk); if (bus.frame_err) ferr_cnt++; end
      chk("glitch_empty", bus.rx_empty, 1);
      chk("glitch_ferr", ferr_cnt, 0);

      // ---- overrun: 9 frames, no pops ----
      for (int k = 0; k < 9; k++) begin
         b = 8'h10 + 8'(k);
         send_rx(b, 1'b1, ^b);
      end
      bit_hold(1'b1);
      chk("ovr_flag", bus.rx_overrun, 1);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("ovr_pop%0d", k), bus.data_out, 8'h10 + k);
         pop1();
      end
      chk("ovr_drained", bus.rx_empty, 1);
      chk("ovr_sticky", bus.rx_overrun, 1);
      bus.rd_en = 1'b1;
      repeat (2) @(negedge clk);
      bus.rd_en = 1'b0;
      chk("ovr_pop_empty", bus.rx_empty, 1);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      chk("ovr_clear", bus.rx_overrun, 0);
      send_rx(8'h5A, 1'b1, ^8'h5A);
      bit_hold(1'b1);
      chk("ovr_after_data", bus.data_out, 8'h5A);
      pop1();

`ifdef OT_UART_PARITY_EN
      // ---- parity check ----
      perr_cnt = 0;
      send_rx(8'h03, 1'b1, 1'b1);
      bit_hold(1'b1);
      chk("par_bad_pulse", perr_cnt, 1);
      chk("par_bad_empty", bus.rx_empty, 1);
      perr_cnt = 0;
      send_rx(8'h03, 1'b1, 1'b0);
      bit_hold(1'b1);
      chk("par_good_pulse", perr_cnt, 0);
      chk("par_good_data", bus.data_out, 8'h03);
      pop1();
`endif

      // ---- TX burst 0x00..0x09 at baud_div=3, looped back ----
      baud_div = 16'd3;
      loop = 1'b1;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         bus.data_in = 8'(i); bus.wr_en = 1'b1;
         if (i == 9) chk("burst_tx_full", bus.tx_full, 1);
         @(negedge clk);
      end
      bus.wr_en = 1'b0;
      for (int c = 0; c < 7500; c++) begin
         if (!bus.rx_empty) begin
            got.push_back(bus.data_out);
            bus.rd_en = 1'b1;
         end else begin
            bus.rd_en = 1'b0;
         end
         @(negedge clk);
      end
      bus.rd_en = 1'b0;
      chk("burst_count", got.size(), 9);
      for (int i = 0; i < 9 && i < got.size(); i++)
         chk($sformatf("burst_byte%0d", i), got[i], 8'(i));
      chk("burst_busy", tx_busy, 0);
      chk("burst_overrun", bus.rx_overrun, 0);

      // ---- reset mid-frame: Tx goes high without a clock edge ----
      loop = 1'b0;
      bus.data_in = 8'h00; bus.wr_en = 1'b1;
      @(negedge clk);
      bus.wr_en = 1'b0;
      t = 0;
      while (tx !== 1'b0 && t < 100) begin @(negedge clk); t++; end
      chk("mid_start_seen", tx, 0);
      repeat (30) @(negedge clk);
      chk("mid_tx_low", tx, 0);
      #3 rstn = 1'b0;
      #2;
      chk("mid_rst_tx", tx, 1);
      chk("mid_rst_busy", tx_busy, 0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_rel_tx", tx, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
